mem_grid: RTL and testbench

MEM_GRID -- requirements
Module: mem_grid

---
 rtl/mem_grid_pkg.sv | 23 ++
 rtl/mem_grid_row.sv | 41 ++++
 rtl/mem_grid.sv | 136 +++++++++++++
 tb/tb_mem_grid.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_grid_pkg.sv
// mem_grid_pkg: shared types and constant helpers for the bit grid.
// Exports state_e (IDLE, CLEAR), clog2() and max1().
package mem_grid_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/mem_grid_row.sv
// mem_grid_row: one COLS-bit row, column-decoded write, sync clear.
// Ports: _clock, _reset, we_i, col_i, data_i, clr_i -> row_o.
module mem_grid_row
    import mem_grid_pkg::*;
#(
    parameter  int COLS = 4,
    localparam int CW   = max1(clog2(COLS))
) (
    input  logic            _clock,
    input  logic            _reset,
    input  logic            we_i,
    input  logic [CW-1:0]   col_i,
    input  logic            data_i,
    input  logic            clr_i,
    output logic [COLS-1:0] row_o
);

    logic [COLS-1:0] row_q;
    logic [COLS-1:0] row_d;

    // Clear wins; the parent never raises both at once.
    always_comb begin
        row_d = row_q;
        if (clr_i) begin
            row_d = '0;
        end else if (we_i) begin
            row_d[col_i] = data_i;
        end
    end

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    assign row_o = row_q;

endmodule

// File: rtl/mem_grid.sv
// mem_grid: ROWS x COLS bit array with 1-cycle reads and bulk clear.
// Ports: _clock, _reset, wr_*, rd_*, clr_req -> return_o, rd_valid,
// rd_err, busy; row_data (whole row) when MEM_GRID_ROWREAD_EN is set.
module mem_grid
    import mem_grid_pkg::*;
#(
    parameter  int ROWS = 4,
    parameter  int COLS = 4,
    localparam int RW   = max1(clog2(ROWS)),
    localparam int CW   = max1(clog2(COLS))
) (
    input  logic            _clock,
    input  logic            _reset,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [CW-1:0]   wr_col,
    input  logic            wr_data,
    input  logic            rd_en,
    input  logic [RW-1:0]   rd_row,
    input  logic [CW-1:0]   rd_col,
    input  logic            clr_req,
    output logic            return_o,
    output logic            rd_valid,
    output logic            rd_err,
    output logic            busy
`ifdef MEM_GRID_ROWREAD_EN
    ,
    output logic [COLS-1:0] row_data
`endif
);

    state_e          state_q;
    logic [RW-1:0]   cnt_q;
    logic            ret_q;
    logic            rv_q;
    logic            err_q;
    logic            busy_q;

    logic [COLS-1:0] grid [ROWS];

    logic            wr_in;
    logic            wr_ok;
    logic            rd_in;
    logic            in_idle;
    logic            in_clr;
    logic [COLS-1:0] rd_bits;

    assign in_idle = (state_q == IDLE);
    assign in_clr  = (state_q == CLEAR);

    assign wr_in = (32'(wr_row) < ROWS) &&
                   (32'(wr_col) < COLS);
    assign rd_in = (32'(rd_row) < ROWS) &&
                   (32'(rd_col) < COLS);

    assign wr_ok = in_idle && wr_en && wr_in;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        mem_grid_row #(
            .COLS (COLS)
        ) u_row (
            ._clock (_clock),
            ._reset (_reset),
            .we_i   (wr_ok && (wr_row == RW'(r))),
            .col_i  (wr_col),
            .data_i (wr_data),
            .clr_i  (in_clr && (cnt_q == RW'(r))),
            .row_o  (grid[r])
        );
    end

    // Out-of-range reads see an all-zero row.
    always_comb begin
        rd_bits = '0;
        if (rd_in) begin
            rd_bits = grid[rd_row];
        end
    end

`ifdef MEM_GRID_ROWREAD_EN
    logic [COLS-1:0] rowd_q;
    assign row_data = rowd_q;
`endif

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ret_q   <= 1'b0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MEM_GRID_ROWREAD_EN
            rowd_q  <= '0;
`endif
        end else begin
            rv_q  <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rd_en) begin
                        rv_q  <= 1'b1;
                        err_q <= !rd_in;
                        ret_q <= rd_bits[rd_col];
`ifdef MEM_GRID_ROWREAD_EN
                        rowd_q <= rd_bits;
`endif
                    end
                    if (clr_req) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt_q == RW'(ROWS - 1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign return_o = ret_q;
    assign rd_valid = rv_q;
    assign rd_err   = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_grid.sv
// tb_mem_grid: scoreboard bench for mem_grid (ROWS=3 and ROWS=8 copies).
// Honours MEM_GRID_ROWREAD_EN for the row_data checks.
module tb_mem_grid;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n   [2];
    logic       wr_en   [2];
    logic [2:0] wr_row  [2];
    logic [1:0] wr_col  [2];
    logic       wr_data [2];
    logic       rd_en   [2];
    logic [2:0] rd_row  [2];
    logic [1:0] rd_col  [2];
    logic       clr_req [2];
    logic       ret     [2];
    logic       rv      [2];
    logic       er      [2];
    logic       bz      [2];
`ifdef MEM_GRID_ROWREAD_EN
    logic [3:0] rowd    [2];
`endif

    mem_grid #(.ROWS(3), .COLS(4)) u_a (
        ._clock   (clk),
        ._reset   (rst_n[0]),
        .wr_en    (wr_en[0]),
        .wr_row   (wr_row[0][1:0]),
        .wr_col   (wr_col[0]),
        .wr_data  (wr_data[0]),
        .rd_en    (rd_en[0]),
        .rd_row   (rd_row[0][1:0]),
        .rd_col   (rd_col[0]),
        .clr_req  (clr_req[0]),
        .return_o (ret[0]),
        .rd_valid (rv[0]),
        .rd_err   (er[0]),
        .busy     (bz[0])
`ifdef MEM_GRID_ROWREAD_EN
        ,
        .row_data (rowd[0])
`endif
    );

    mem_grid #(.ROWS(8), .COLS(4)) u_b (
        ._clock   (clk),
        ._reset   (rst_n[1]),
        .wr_en    (wr_en[1]),
        .wr_row   (wr_row[1]),
        .wr_col   (wr_col[1]),
        .wr_data  (wr_data[1]),
        .rd_en    (rd_en[1]),
        .rd_row   (rd_row[1]),
        .rd_col   (rd_col[1]),
        .clr_req  (clr_req[1]),
        .return_o (ret[1]),
        .rd_valid (rv[1]),
        .rd_err   (er[1]),
        .busy     (bz[1])
`ifdef MEM_GRID_ROWREAD_EN
        ,
        .row_data (rowd[1])
`endif
    );

    typedef struct {
        logic       ret;
        logic       err;
        logic [3:0] row;
        int         cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d",
                     nm, act, req);
        end
    endtask

    task automatic push(input int d, input logic r,
                        input logic e, input logic [3:0] row);
        exp_t x;
        x.ret = r;
        x.err = e;
        x.row = row;
        x.cyc = cyc + 1;
        if (d == 0) qa.push_back(x);
        else        qb.push_back(x);
    endtask

    task automatic cmp(input int d, input logic r,
                       input logic e, input logic [3:0] row);
        exp_t x;
        if ((d == 0 && qa.size() == 0) ||
            (d == 1 && qb.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexp_valid%0d: got rd_valid=1 at cyc %0d expected 0",
                     d, cyc);
        end else begin
            if (d == 0) x = qa.pop_front();
            else        x = qb.pop_front();
            chk($sformatf("ret%0d", d), r, x.ret);
            chk($sformatf("err%0d", d), e, x.err);
            chk($sformatf("lat%0d", d), cyc, x.cyc);
`ifdef MEM_GRID_ROWREAD_EN
            chk($sformatf("row%0d", d), row, x.row);
`else
            if (row !== 4'h0) chk("row_stub", row, 0);
`endif
        end
    endtask

    task automatic mon();
        forever begin
            @(negedge clk);
`ifdef MEM_GRID_ROWREAD_EN
            if (rv[0]) cmp(0, ret[0], er[0], rowd[0]);
            if (rv[1]) cmp(1, ret[1], er[1], rowd[1]);
`else
            if (rv[0]) cmp(0, ret[0], er[0], 4'h0);
            if (rv[1]) cmp(1, ret[1], er[1], 4'h0);
`endif
        end
    endtask

    task automatic drive(input int d,
                         input bit we, input int wr,
                         input int wc, input bit wd,
                         input bit re, input int rr,
                         input int rc, input bit clr);
        wr_en[d]   = we;
        wr_row[d]  = 3'(wr);
        wr_col[d]  = 2'(wc);
        wr_data[d] = wd;
        rd_en[d]   = re;
        rd_row[d]  = 3'(rr);
        rd_col[d]  = 2'(rc);
        clr_req[d] = clr;
        @(posedge clk);
        #1;
        wr_en[d]   = 1'b0;
        rd_en[d]   = 1'b0;
        clr_req[d] = 1'b0;
    endtask

    task automatic wr(input int d, input int r,
                      input int c, input bit v);
        drive(d, 1, r, c, v, 0, 0, 0, 0);
    endtask

    task automatic rd(input int d, input int r, input int c,
                      input logic er_ret, input logic er_err,
                      input logic [3:0] er_row);
        push(d, er_ret, er_err, er_row);
        drive(d, 0, 0, 0, 0, 1, r, c, 0);
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            rst_n[d]   = 1'b0;
            wr_en[d]   = 1'b0;
            wr_row[d]  = '0;
            wr_col[d]  = '0;
            wr_data[d] = 1'b0;
            rd_en[d]   = 1'b0;
            rd_row[d]  = '0;
            rd_col[d]  = '0;
            clr_req[d] = 1'b0;
        end
        fork
            mon();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ret", ret[d], 0);
            chk("rst_valid", rv[d], 0);
            chk("rst_err", er[d], 0);
            chk("rst_busy", bz[d], 0);
`ifdef MEM_GRID_ROWREAD_EN
            chk("rst_row", rowd[d], 0);
`endif
        end
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(posedge clk);
        #1;

        // basic write then read
        wr(0, 2, 3, 1);
        rd(0, 2, 3, 1, 0, 4'b1000);

        // read-before-write on the same cell
        push(0, 0, 0, 4'b0000);
        drive(0, 1, 1, 1, 1, 1, 1, 1, 0);
        rd(0, 1, 1, 1, 0, 4'b0010);

        // out-of-range row (ROWS=3)
        wr(0, 3, 0, 1);
        rd(0, 3, 0, 0, 1, 4'b0000);
        rd(0, 0, 0, 0, 0, 4'b0000);

        // whole-row read
        wr(0, 2, 1, 1);
        rd(0, 2, 0, 0, 0, 4'b1010);

        // fill, then clear with a read on the same edge
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                wr(0, r, c, 1);
        rd(0, 0, 2, 1, 0, 4'b1111);
        push(0, 1, 0, 4'b1111);
        drive(0, 0, 0, 0, 0, 1, 2, 0, 1);
        chk("busy_rise", bz[0], 1);

        wr_en[0]   = 1'b1;
        wr_row[0]  = 3'd0;
        wr_col[0]  = 2'd0;
        wr_data[0] = 1'b1;
        rd_en[0]   = 1'b1;
        rd_row[0]  = 3'd1;
        rd_col[0]  = 2'd1;
        clr_req[0] = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bz[0]) break;
            n++;
        end
        wr_en[0]   = 1'b0;
        rd_en[0]   = 1'b0;
        clr_req[0] = 1'b0;
        chk("busy_cycles", n, 3);

        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                rd(0, r, c, 0, 0, 4'b0000);
        chk("idle_after_clr", bz[0], 0);

        // reset in the middle of a clear (ROWS=8)
        wr(1, 7, 3, 1);
        wr(1, 0, 0, 1);
        wr(1, 5, 2, 1);
        rd(1, 7, 3, 1, 0, 4'b1000);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("busy_mid", bz[1], 1);
        rst_n[1] = 1'b0;
        #1;
        chk("abort_busy", bz[1], 0);
        chk("abort_valid", rv[1], 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_rst", bz[1], 0);
        rd(1, 7, 3, 0, 0, 4'b0000);
        rd(1, 5, 2, 0, 0, 4'b0000);
        rd(1, 0, 0, 0, 0, 4'b0000);
        wr(1, 3, 1, 1);
        rd(1, 3, 1, 1, 0, 4'b0010);

        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
